minc_prog_loader: RTL and testbench

//  Writer side of the minc 9-bit program memory: takes a framed byte stream (from a UART RX or

---
 rtl/minc_prog_loader_pkg.sv | 27 ++
 rtl/minc_prog_loader_timer.sv | 30 +++
 rtl/minc_prog_loader.sv | 122 ++++++++++++
 tb/tb_minc_prog_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/minc_prog_loader_pkg.sv
// Shared constants, state encoding and helpers for the minc program loader.
package minc_prog_loader_pkg;

  localparam logic [7:0] MINC_SYNC_BYTE = 8'hA5;
  localparam int         MINC_IW        = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_LO    = 3'd2,
    ST_HI    = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } loader_state_e;

  // Only bit 0 of a HI byte carries opcode information; anything else is a corrupt frame.
  function automatic logic hi_byte_ok(input logic [7:0] b);
    return (b[7:1] == 7'd0);
  endfunction

  // States in which the inter-byte timeout is armed.
  function automatic logic in_frame(input loader_state_e s);
    return (s == ST_COUNT) || (s == ST_LO) || (s == ST_HI) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/minc_prog_loader_timer.sv
// Clearable saturating cycle counter that flags when LIMIT idle cycles have elapsed.
module minc_loader_timer #(
  parameter int LIMIT = 1000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [W-1:0] count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count != {W{1'b1}}) begin
      count <= count + W'(1);
    end
  end

  // Asserted during the LIMIT-th idle cycle so the loader aborts on that cycle's edge.
  assign expired = (LIMIT != 0) && enable && (count >= LAST);

endmodule

// File: rtl/minc_prog_loader.sv
// Writer side of the minc 9-bit program memory: parses SYNC/COUNT/{LO,HI}*/CSUM frames
// and holds the CPU in reset while a load is in flight.
module minc_prog_loader
  import minc_prog_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter bit BOOT_RUN       = 1'b1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [7:0]         mem_addr,
  output logic [MINC_IW-1:0] mem_wdata,
  output logic               cpu_nreset,
  output logic               busy,
  output logic               done,
  output logic               error
);

  loader_state_e state;
  logic [8:0]    remaining;
  logic [7:0]    lo_byte;
  logic [7:0]    csum;
  logic [7:0]    addr;
  logic          accept;
  logic          timeout;

  assign in_ready = 1'b1;
  assign accept   = in_valid && in_ready;

  minc_loader_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (accept),
    .enable  (in_frame(state)),
    .expired (timeout)
  );

  // Single FSM with registered outputs; an accepted byte always takes priority over timeout.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      lo_byte    <= '0;
      csum       <= '0;
      addr       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_nreset <= BOOT_RUN;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (in_data == MINC_SYNC_BYTE) begin
              state      <= ST_COUNT;
              done       <= 1'b0;
              error      <= 1'b0;
              cpu_nreset <= 1'b0;
              busy       <= 1'b1;
            end
          end
          ST_COUNT: begin
            remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            csum      <= in_data;
            addr      <= '0;
            state     <= ST_LO;
          end
          ST_LO: begin
            lo_byte <= in_data;
            csum    <= csum + in_data;
            state   <= ST_HI;
          end
          ST_HI: begin
            if (!hi_byte_ok(in_data)) begin
              state <= ST_ERROR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else begin
              csum      <= csum + in_data;
              mem_we    <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= {in_data[0], lo_byte};
              // An 8-bit address wraps 255 -> 0 naturally after a 256-word image.
              addr      <= addr + 8'd1;
              remaining <= remaining - 9'd1;
              state     <= (remaining == 9'd1) ? ST_CHECK : ST_LO;
            end
          end
          ST_CHECK: begin
            busy <= 1'b0;
            if (in_data == csum) begin
              state      <= ST_DONE;
              done       <= 1'b1;
              cpu_nreset <= 1'b1;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end else if (timeout) begin
        state <= ST_ERROR;
        error <= 1'b1;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_minc_prog_loader.sv
// Scoreboard bench for minc_prog_loader: stimulus queues expected writes, a monitor checks mem_we.
module tb_minc_prog_loader;

  localparam int TO = 1000;

  logic       CLK;
  logic       RESET;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [8:0] mem_wdata;
  logic       cpu_nreset;
  logic       busy;
  logic       done;
  logic       error;

  logic       b_in_ready;
  logic       b_mem_we;
  logic [7:0] b_mem_addr;
  logic [8:0] b_mem_wdata;
  logic       b_cpu_nreset;
  logic       b_busy;
  logic       b_done;
  logic       b_error;

  typedef struct packed {
    logic [7:0] addr;
    logic [8:0] data;
  } wr_t;

  wr_t expQ[$];
  int  assertCount = 0;
  int  failCount   = 0;

  minc_prog_loader #(.TIMEOUT_CYCLES(TO), .BOOT_RUN(1'b1)) u_dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_nreset(cpu_nreset),
    .busy(busy), .done(done), .error(error)
  );

  minc_prog_loader #(.TIMEOUT_CYCLES(TO), .BOOT_RUN(1'b0)) u_dut_b (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .cpu_nreset(b_cpu_nreset), .busy(b_busy), .done(b_done), .error(b_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge CLK) begin
    if (!RESET && mem_we) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write_addr", {24'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("write_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        checkOutput("write_data", {23'd0, mem_wdata}, {23'd0, e.data});
      end
    end
  end

  // Drive one byte for one cycle; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    checkOutput("in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [7:0] a, input logic [7:0] lo, input logic [7:0] hi,
                          input logic [8:0] expData, input bit expectWrite);
    wr_t e;
    applyStimulus(lo);
    if (expectWrite) begin
      e.addr = a;
      e.data = expData;
      expQ.push_back(e);
    end
    applyStimulus(hi);
  endtask

  task automatic sendFrame1(input logic [7:0] cs);
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    sendWord(8'd0, 8'h05, 8'h01, 9'h105, 1'b1);
    sendWord(8'd1, 8'h03, 8'h00, 9'h003, 1'b1);
    applyStimulus(cs);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESET    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    checkOutput("rst_mem_wdata", {23'd0, mem_wdata}, 32'd0);
    checkOutput("rst_cpu_nreset", {31'd0, cpu_nreset}, 32'd1);
    checkOutput("rst_b_cpu_nreset", {31'd0, b_cpu_nreset}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_error", {31'd0, error}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    $display("[TB] test 1: good two-word frame");
    applyStimulus(8'hA5);
    checkOutput("t1_cpu_nreset_low", {31'd0, cpu_nreset}, 32'd0);
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    applyStimulus(8'h02);
    sendWord(8'd0, 8'h05, 8'h01, 9'h105, 1'b1);
    sendWord(8'd1, 8'h03, 8'h00, 9'h003, 1'b1);
    checkOutput("t1_done_before_csum", {31'd0, done}, 32'd0);
    applyStimulus(8'h0B);
    checkOutput("t1_done", {31'd0, done}, 32'd1);
    checkOutput("t1_error", {31'd0, error}, 32'd0);
    checkOutput("t1_cpu_nreset_high", {31'd0, cpu_nreset}, 32'd1);
    checkOutput("t1_busy_end", {31'd0, busy}, 32'd0);
    checkOutput("t1_b_cpu_nreset", {31'd0, b_cpu_nreset}, 32'd1);

    $display("[TB] test 2: bad checksum");
    sendFrame1(8'h0C);
    checkOutput("t2_error", {31'd0, error}, 32'd1);
    checkOutput("t2_done", {31'd0, done}, 32'd0);
    checkOutput("t2_cpu_nreset", {31'd0, cpu_nreset}, 32'd0);

    $display("[TB] test 3: invalid HI byte then recovery");
    applyStimulus(8'hA5);
    checkOutput("t3_error_cleared", {31'd0, error}, 32'd0);
    applyStimulus(8'h01);
    sendWord(8'd0, 8'h07, 8'h02, 9'h000, 1'b0);
    checkOutput("t3_error", {31'd0, error}, 32'd1);
    checkOutput("t3_busy", {31'd0, busy}, 32'd0);
    sendFrame1(8'h0B);
    checkOutput("t3_done", {31'd0, done}, 32'd1);
    checkOutput("t3_error_after", {31'd0, error}, 32'd0);

    $display("[TB] test 4: inter-byte timeout");
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h07);
    repeat (TO - 1) @(posedge CLK);
    #1;
    checkOutput("t4_no_timeout_yet", {31'd0, error}, 32'd0);
    checkOutput("t4_busy_yet", {31'd0, busy}, 32'd1);
    @(posedge CLK);
    #1;
    checkOutput("t4_error", {31'd0, error}, 32'd1);
    checkOutput("t4_busy", {31'd0, busy}, 32'd0);
    checkOutput("t4_cpu_nreset", {31'd0, cpu_nreset}, 32'd0);
    applyStimulus(8'h55);
    applyStimulus(8'h01);
    checkOutput("t4_garbage_error", {31'd0, error}, 32'd1);
    checkOutput("t4_garbage_busy", {31'd0, busy}, 32'd0);

    $display("[TB] test 5: 256-word image");
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    for (int i = 0; i < 256; i++) begin
      sendWord(8'(i), 8'(i), 8'(i & 1), {1'(i & 1), 8'(i)}, 1'b1);
      if (i == 254) begin
        checkOutput("t5_busy_mid", {31'd0, busy}, 32'd1);
        checkOutput("t5_done_mid", {31'd0, done}, 32'd0);
      end
    end
    applyStimulus(8'h00);
    checkOutput("t5_done", {31'd0, done}, 32'd1);
    checkOutput("t5_error", {31'd0, error}, 32'd0);
    checkOutput("t5_cpu_nreset", {31'd0, cpu_nreset}, 32'd1);

    $display("[TB] test 6: reset mid-word, BOOT_RUN=0 instance");
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h05);
    RESET = 1'b1;
    #1;
    checkOutput("t6_busy", {31'd0, busy}, 32'd0);
    checkOutput("t6_done", {31'd0, done}, 32'd0);
    checkOutput("t6_error", {31'd0, error}, 32'd0);
    checkOutput("t6_mem_addr", {24'd0, mem_addr}, 32'd0);
    checkOutput("t6_mem_wdata", {23'd0, mem_wdata}, 32'd0);
    checkOutput("t6_cpu_nreset", {31'd0, cpu_nreset}, 32'd1);
    checkOutput("t6_b_cpu_nreset", {31'd0, b_cpu_nreset}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("t6_b_hold", {31'd0, b_cpu_nreset}, 32'd0);
    sendFrame1(8'h0B);
    checkOutput("t6_b_done", {31'd0, b_done}, 32'd1);
    checkOutput("t6_b_release", {31'd0, b_cpu_nreset}, 32'd1);
    checkOutput("t6_done", {31'd0, done}, 32'd1);

    repeat (3) @(posedge CLK);
    #1;
    checkOutput("pending_writes", expQ.size(), 32'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
